// File: rtl/halut_decoder_int.sv
// halut_decoder_int: INT LUT-accumulate decoder for one output column; define HALUT_DEC_SATURATE_EN for saturating accumulation
module halut_decoder_int #(
  parameter int K = 16,
  parameter int C = 32,
  parameter int M = 32,
  parameter int DataTypeWidth = 16,
  parameter int AccWidth = 32,
  localparam int KW = K > 1 ? $clog2(K) : 1,
  localparam int CW = C > 1 ? $clog2(C) : 1,
  localparam int MW = M > 1 ? $clog2(M) : 1,
  localparam int AW = C * K > 1 ? $clog2(C * K) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [KW-1:0]            k_addr_i,
  input  logic [CW-1:0]            c_addr_i,
  input  logic [MW-1:0]            m_addr_i,
  output logic                     lut_req_o,
  output logic [AW-1:0]            lut_addr_o,
  input  logic [DataTypeWidth-1:0] lut_data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [AccWidth-1:0]      result_o,
  output logic [MW-1:0]            result_m_o,
  output logic                     seq_err_o
);
  logic s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic valid_q, valid_d, seq_err_q, seq_err_d;
  logic [AccWidth-1:0] acc_q, acc_d, result_q, result_d, base, ext, sum;
  logic [MW-1:0] m_q, m_d, result_m_q, result_m_d;
  logic [CW-1:0] exp_c_q, exp_c_d;
  logic accept, c_last, out_wr;

  // a full or about-to-be-filled output slot blocks new beats so S1 never has to stall
  assign ready_o    = ~(valid_q & ~ready_i) & ~(s1_valid_q & s1_last_q);
  assign accept     = valid_i & ready_o;
  assign lut_req_o  = accept;
  assign lut_addr_o = AW'(c_addr_i) * AW'(K) + AW'(k_addr_i);
  assign c_last     = c_addr_i == CW'(C - 1);
  assign out_wr     = s1_valid_q & s1_last_q;
  assign base       = s1_first_q ? '0 : acc_q;
  assign ext        = AccWidth'($signed(lut_data_i));

`ifdef HALUT_DEC_SATURATE_EN
  logic [AccWidth:0] wide;
  // one guard bit detects overflow; clamp towards the sign of the true sum
  always_comb begin
    wide = {base[AccWidth-1], base} + {ext[AccWidth-1], ext};
    sum  = wide[AccWidth] == wide[AccWidth-1] ? wide[AccWidth-1:0] : {wide[AccWidth], {(AccWidth-1){~wide[AccWidth]}}};
  end
`else
  assign sum = base + ext;
`endif

  // next state: S0 capture, sequence tracking, S1 accumulate and output slot
  always_comb begin
    s1_valid_d = accept;
    s1_first_d = accept & (c_addr_i == '0);
    s1_last_d  = accept & c_last;
    m_d        = accept && c_addr_i == '0 ? m_addr_i : m_q;
    exp_c_d    = accept ? (c_last ? '0 : c_addr_i + CW'(1)) : exp_c_q;
    seq_err_d  = seq_err_q | (accept & (c_addr_i != exp_c_q));
    acc_d      = s1_valid_q & ~s1_last_q ? sum : acc_q;
    valid_d    = out_wr | (valid_q & ~ready_i);
    result_d   = out_wr ? sum : result_q;
    result_m_d = out_wr ? m_q : result_m_q;
  end

  // state registers, cleared asynchronously so an in-flight LUT response is discarded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      m_q        <= '0;
      exp_c_q    <= '0;
      seq_err_q  <= 1'b0;
      acc_q      <= '0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      result_m_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      m_q        <= m_d;
      exp_c_q    <= exp_c_d;
      seq_err_q  <= seq_err_d;
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      result_m_q <= result_m_d;
    end
  end

  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign result_m_o = result_m_q;
  assign seq_err_o  = seq_err_q;
endmodule

// File: tb/tb_halut_decoder_int.sv
// tb_halut_decoder_int: randomized checks of halut_decoder_int (C=4/16-bit acc and C=1/32-bit acc instances)
module tb_halut_decoder_int;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic v0 = 0, rdy0, req0, vo0, ri0 = 1, err0;
  logic [3:0] k0 = 0;
  logic [1:0] c0 = 0;
  logic [4:0] m0 = 0, rm0;
  logic [5:0] addr0;
  logic [15:0] lut0 = 0, res0;
  logic v1 = 0, rdy1, req1, vo1, ri1 = 1, err1, c1 = 0;
  logic [3:0] k1 = 0, addr1;
  logic [4:0] m1 = 0, rm1;
  logic [15:0] lut1 = 0;
  logic [31:0] res1;
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [16];
  int cyc = 0, n_cmp = 0, n_bad = 0, last_acc0 = 0;

  typedef struct packed {logic [15:0] r; logic [4:0] m; int t;} rec0_t;
  typedef struct packed {logic [31:0] r; int t;} rec1_t;
  rec0_t got0[$];
  rec1_t got1[$];

  halut_decoder_int #(.K(16), .C(4), .M(32), .DataTypeWidth(16), .AccWidth(16)) d0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v0), .ready_o(rdy0), .k_addr_i(k0), .c_addr_i(c0),
    .m_addr_i(m0), .lut_req_o(req0), .lut_addr_o(addr0), .lut_data_i(lut0), .valid_o(vo0),
    .ready_i(ri0), .result_o(res0), .result_m_o(rm0), .seq_err_o(err0));

  halut_decoder_int #(.K(16), .C(1), .M(32), .DataTypeWidth(16), .AccWidth(32)) d1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(rdy1), .k_addr_i(k1), .c_addr_i(c1),
    .m_addr_i(m1), .lut_req_o(req1), .lut_addr_o(addr1), .lut_data_i(lut1), .valid_o(vo1),
    .ready_i(ri1), .result_o(res1), .result_m_o(rm1), .seq_err_o(err1));

  // SRAM models: data one cycle after a request, junk otherwise
  always @(posedge clk) lut0 <= req0 ? mem0[addr0] : 16'($urandom);
  always @(posedge clk) lut1 <= req1 ? mem1[addr1] : 16'($urandom);
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && vo0 && ri0) got0.push_back({res0, rm0, cyc});
  always @(posedge clk) if (rst_n && vo1 && ri1) got1.push_back({res1, cyc});

  function automatic logic [15:0] col_sum(input logic [15:0] e[$]);
    longint a = 0;
    foreach (e[i]) begin
      a += longint'($signed(e[i]));
`ifdef HALUT_DEC_SATURATE_EN
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
`else
      a = longint'($signed(16'(a)));
`endif
    end
    return 16'(a);
  endfunction

  task automatic beat0(input int cc, input int kk, input int mm);
    int w = 0;
    v0 = 1; c0 = 2'(cc); k0 = 4'(kk); m0 = 5'(mm);
    #1;
    while (rdy0 !== 1'b1 && w < 40) begin @(posedge clk); #2; w++; end
    n_cmp++;
    if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL beat_accept: ready_o %b after %0d cycles, required 1", rdy0, w); end
    n_cmp++;
    if (req0 !== 1'b1 || addr0 !== 6'(cc * 16 + kk)) begin
      n_bad++; $display("FAIL lut_req_addr: req %b addr %0d, required 1 %0d", req0, addr0, cc * 16 + kk);
    end
    @(posedge clk); #1;
    last_acc0 = cyc - 1;
    v0 = 0;
  endtask

  task automatic put0(input int cc, input logic [15:0] v, input int mm);
    int kk = $urandom_range(0, 15);
    mem0[cc * 16 + kk] = v;
    beat0(cc, kk, mm);
  endtask

  task automatic col0(input int mm, input logic [15:0] vals[$], input int gap);
    foreach (vals[i]) begin
      put0(i, vals[i], mm);
      repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({rdy0, req0, vo0, err0, rdy1, vo1, err1} !== 7'b1000100) begin
      n_bad++; $display("FAIL reset_flags: rdy/req/vld/err d0 %b%b%b%b d1 %b%b%b, required 1000 100", rdy0, req0, vo0, err0, rdy1, vo1, err1);
    end
    n_cmp++;
    if (res0 !== 16'd0 || rm0 !== 5'd0 || res1 !== 32'd0) begin
      n_bad++; $display("FAIL reset_result: %h %0d %h, required 0 0 0", res0, rm0, res1);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] v[$];
    v = {16'd10, 16'hFFFD, 16'd7, 16'd1};
    got0.delete();
    col0(5, v, 0);
    for (int i = 0; i < 20 && got0.size() < 1; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (got0.size() < 1) begin n_bad++; $display("FAIL basic_timeout: %0d results, required 1", got0.size()); end
    else begin
      n_cmp++;
      if (got0[0].r !== 16'd15 || got0[0].m !== 5'd5) begin
        n_bad++; $display("FAIL basic_sum: %0d m %0d, required 15 m 5", $signed(got0[0].r), got0[0].m);
      end
      n_cmp++;
      if (got0[0].t !== last_acc0 + 2) begin
        n_bad++; $display("FAIL basic_latency: %0d cycles, required 2", got0[0].t - last_acc0);
      end
    end
    n_cmp++;
    if (err0 !== 1'b0) begin n_bad++; $display("FAIL basic_seq_err: %b, required 0", err0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va[$], vb[$], ea, eb;
    int w = 0;
    for (int i = 0; i < 4; i++) begin va.push_back(16'($urandom)); vb.push_back(16'($urandom)); end
    ea = col_sum(va); eb = col_sum(vb);
    ri0 = 0;
    got0.delete();
    fork
      begin col0(7, va, 0); col0(9, vb, 0); end
      begin
        #1;
        while (vo0 !== 1'b1 && w < 40) begin @(posedge clk); #2; w++; end
        n_cmp++;
        if (vo0 !== 1'b1) begin n_bad++; $display("FAIL b2b_first_valid: valid_o %b, required 1", vo0); end
        repeat (5) begin
          n_cmp++;
          if (vo0 !== 1'b1 || res0 !== ea || rm0 !== 5'd7) begin
            n_bad++; $display("FAIL b2b_hold: valid %b result %h m %0d, required 1 %h 7", vo0, res0, rm0, ea);
          end
          n_cmp++;
          if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_low: ready_o %b, required 0", rdy0); end
          @(posedge clk); #2;
        end
        @(posedge clk); #1;
        ri0 = 1;
      end
    join
    for (int i = 0; i < 30 && got0.size() < 2; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (got0.size() != 2) begin n_bad++; $display("FAIL b2b_count: %0d results, required 2", got0.size()); end
    else begin
      n_cmp++;
      if (got0[0].r !== ea || got0[0].m !== 5'd7) begin n_bad++; $display("FAIL b2b_first: %h m %0d, required %h m 7", got0[0].r, got0[0].m, ea); end
      n_cmp++;
      if (got0[1].r !== eb || got0[1].m !== 5'd9) begin n_bad++; $display("FAIL b2b_second: %h m %0d, required %h m 9", got0[1].r, got0[1].m, eb); end
    end
  endtask

  task automatic test_c1();
    for (int i = 0; i < 16; i++) mem1[i] = 16'hFFF8;
    got1.delete();
    v1 = 1;
    for (int i = 0; i < 20; i++) begin k1 = 4'($urandom); @(posedge clk); #1; end
    v1 = 0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++;
    if (got1.size() != 10) begin n_bad++; $display("FAIL c1_count: %0d results, required 10", got1.size()); end
    foreach (got1[i]) begin
      n_cmp++;
      if (got1[i].r !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL c1_value[%0d]: %h, required fffffff8", i, got1[i].r); end
      if (i > 0) begin
        n_cmp++;
        if (got1[i].t - got1[i-1].t !== 2) begin n_bad++; $display("FAIL c1_spacing[%0d]: %0d cycles, required 2", i, got1[i].t - got1[i-1].t); end
      end
    end
    n_cmp++;
    if (err1 !== 1'b0) begin n_bad++; $display("FAIL c1_seq_err: %b, required 0", err1); end
  endtask

  task automatic test_seq_err();
    logic [15:0] v[$], e;
    for (int i = 0; i < 3; i++) v.push_back(16'($urandom_range(0, 2000)));
    e = col_sum(v);
    got0.delete();
    put0(0, v[0], 3);
    n_cmp++;
    if (err0 !== 1'b0) begin n_bad++; $display("FAIL seq_before: %b, required 0", err0); end
    put0(2, v[1], 3);
    n_cmp++;
    if (err0 !== 1'b1) begin n_bad++; $display("FAIL seq_rise: %b, required 1", err0); end
    put0(3, v[2], 3);
    v.delete();
    for (int i = 0; i < 4; i++) v.push_back(16'($urandom));
    col0(11, v, 1);
    for (int i = 0; i < 20 && got0.size() < 2; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (got0.size() != 2) begin n_bad++; $display("FAIL seq_count: %0d results, required 2", got0.size()); end
    else begin
      n_cmp++;
      if (got0[0].r !== e || got0[0].m !== 5'd3) begin n_bad++; $display("FAIL seq_skip_sum: %h m %0d, required %h m 3", got0[0].r, got0[0].m, e); end
      n_cmp++;
      if (got0[1].r !== col_sum(v) || got0[1].m !== 5'd11) begin n_bad++; $display("FAIL seq_next_sum: %h, required %h", got0[1].r, col_sum(v)); end
    end
    n_cmp++;
    if (err0 !== 1'b1) begin n_bad++; $display("FAIL seq_sticky: %b, required 1", err0); end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (err0 !== 1'b0) begin n_bad++; $display("FAIL seq_reset_clear: %b, required 0", err0); end
    @(posedge clk); #1;
    rst_n = 1;
    put0(1, 16'd1, 2);
    n_cmp++;
    if (err0 !== 1'b1) begin n_bad++; $display("FAIL seq_after_reset: %b, required 1", err0); end
    put0(2, 16'd1, 2);
    put0(3, 16'd1, 2);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_saturate();
    logic [15:0] vn[$], vp[$];
    vn = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vp = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    got0.delete();
    col0(1, vn, 0);
    col0(2, vp, 0);
    for (int i = 0; i < 20 && got0.size() < 2; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (got0.size() != 2) begin n_bad++; $display("FAIL sat_count: %0d results, required 2", got0.size()); end
    else begin
`ifdef HALUT_DEC_SATURATE_EN
      n_cmp++;
      if (got0[0].r !== 16'h8000) begin n_bad++; $display("FAIL sat_neg: %h, required 8000", got0[0].r); end
      n_cmp++;
      if (got0[1].r !== 16'h7FFF) begin n_bad++; $display("FAIL sat_pos: %h, required 7fff", got0[1].r); end
`else
      n_cmp++;
      if (got0[0].r !== 16'h0000) begin n_bad++; $display("FAIL wrap_neg: %h, required 0000", got0[0].r); end
      n_cmp++;
      if (got0[1].r !== 16'hFFFC) begin n_bad++; $display("FAIL wrap_pos: %h, required fffc", got0[1].r); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v[$];
    v = {16'd1, 16'd1, 16'd1, 16'd1};
    put0(0, 16'd1, 2);
    put0(1, 16'd1, 2);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({vo0, err0, rdy0, req0} !== 4'b0010 || res0 !== 16'd0 || rm0 !== 5'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs: vld %b err %b rdy %b req %b res %h m %0d, required 0 0 1 0 0 0", vo0, err0, rdy0, req0, res0, rm0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    got0.delete();
    col0(6, v, 0);
    for (int i = 0; i < 20 && got0.size() < 1; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (got0.size() != 1 || got0[0].r !== 16'd4 || got0[0].m !== 5'd6) begin
      n_bad++; $display("FAIL mid_fresh_column: %0d results, first %h, required 1 result 0004 m 6", got0.size(), got0.size() ? got0[0].r : 16'hx);
    end
    n_cmp++;
    if (err0 !== 1'b0) begin n_bad++; $display("FAIL mid_seq_err: %b, required 0", err0); end
  endtask

  task automatic test_random();
    logic [15:0] exq[$], v[$];
    logic [4:0] emq[$];
    bit done = 0;
    got0.delete();
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          int mm = $urandom_range(0, 31);
          v.delete();
          for (int i = 0; i < 4; i++) v.push_back(16'($urandom));
          exq.push_back(col_sum(v));
          emq.push_back(5'(mm));
          col0(mm, v, 2);
        end
        done = 1;
      end
      while (!done) begin @(posedge clk); #1; ri0 = $urandom_range(0, 3) != 0; end
    join
    ri0 = 1;
    for (int i = 0; i < 100 && got0.size() < 30; i++) begin @(posedge clk); #1; end
    n_cmp++;
    if (got0.size() != 30) begin n_bad++; $display("FAIL rand_count: %0d results, required 30", got0.size()); end
    for (int i = 0; i < 30 && i < got0.size(); i++) begin
      n_cmp++;
      if (got0[i].r !== exq[i] || got0[i].m !== emq[i]) begin
        n_bad++; $display("FAIL rand_col[%0d]: %h m %0d, required %h m %0d", i, got0[i].r, got0[i].m, exq[i], emq[i]);
      end
    end
    n_cmp++;
    if (err0 !== 1'b0) begin n_bad++; $display("FAIL rand_seq_err: %b, required 0", err0); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem0[i] = 16'h0;
    for (int i = 0; i < 16; i++) mem1[i] = 16'h0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_c1();
    test_seq_err();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/halut_decoder_int.md
# halut_decoder_int

Integer decoder stage of the halut datapath, sitting directly downstream of the encoder. For one output column `m`, it consumes the stream of encoded prototype indices, one per codebook `c = 0..C-1`. Each index is turned into a read request to the external LUT SRAM, and the returned signed LUT entries are summed into one accumulator. The finished column sum is presented on a valid/ready output port. This block is the INT accumulation variant; `DecoderUnits` instances are placed in parallel.

## Interface
Parameters:
- `K`, 16: prototypes per codebook.
- `C`, 32: number of codebooks, i.e. terms per column sum. Must be ≥ 1.
- `M`, 32: number of output columns.
- `DataTypeWidth`, 16: width of a signed LUT entry.
- `AccWidth`, 32: width of the signed accumulator and result. Must be ≥ `DataTypeWidth`.

Ports (clock and reset first):
- `clk_i` in 1: single clock. All flops are rising-edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `valid_i` in 1: input beat valid.
- `ready_o` out 1: input beat accepted when `valid_i & ready_o`.
- `k_addr_i` in `$clog2(K)`: encoded prototype index.
- `c_addr_i` in `$clog2(C)`: codebook index of the beat.
- `m_addr_i` in `$clog2(M)`: column index. Sampled only on beats with `c_addr_i==0`.
- `lut_req_o` out 1: LUT read strobe. Equals `valid_i & ready_o`.
- `lut_addr_o` out `$clog2(C*K)`: LUT address, `c_addr_i*K + k_addr_i`. Combinational from the inputs.
- `lut_data_i` in `DataTypeWidth`: signed LUT entry, valid exactly 1 cycle after `lut_req_o`.
- `valid_o` out 1: result valid.
- `ready_i` in 1: result consumed when `valid_o & ready_i`.
- `result_o` out `AccWidth`: signed column sum.
- `result_m_o` out `$clog2(M)`: column index belonging to `result_o`.
- `seq_err_o` out 1: sticky flag for an out-of-order codebook index.

## Operation
Pipeline:
- **S0 (accept):** an accepted beat drives `lut_req_o`/`lut_addr_o` in the same cycle. It registers `s1_valid_q`, `s1_first_q = (c_addr_i==0)` and `s1_last_q = (c_addr_i==C-1)`.
- **S1 (accumulate):** `lut_data_i` is sign-extended to `AccWidth`. The term is `first ? 0 : acc_q`, plus the extended entry.
  - Non-last beat: the sum is written to `acc_q`.
  - Last beat: the sum is written to `result_o`, `m_q` is copied to `result_m_o`, and `valid_o` is set.
  - Beat that is both first and last (`C==1`): the result is the sign-extended entry alone.

Rules:
- **Backpressure:** `ready_o = ~(valid_o & ~ready_i) & ~(s1_valid_q & s1_last_q)`.
  - This guarantees the output slot is free whenever S1 writes it. S1 never stalls, so it never drops `lut_data_i`.
- **Output hold:** while `valid_o & ~ready_i`, `valid_o`, `result_o` and `result_m_o` hold stable. A pop without a simultaneous S1 write clears `valid_o` next cycle.
- **Sequence check:** an internal expected counter `exp_c_q` starts at 0. On every accepted beat it advances, wrapping from `C-1` to 0.
  - If an accepted `c_addr_i != exp_c_q`, `seq_err_o` sets and stays high until reset.
  - The beat is still processed by its own `c_addr_i`, and `exp_c_q` resyncs to `c_addr_i+1` (with the same wrap).
- **Gaps:** `valid_i` gaps between beats of one column are allowed and the accumulator holds across them.

## Timing
- Reset values:
  - `ready_o`: 1. This follows combinationally from the cleared state.
  - `lut_req_o`: 0 (it follows `valid_i & ready_o`).
  - `valid_o`, `result_o`, `result_m_o`, `seq_err_o`, `acc_q`, `exp_c_q`, `s1_*`: all 0.
- Latency: last beat accepted in cycle t gives `valid_o` high from t+2.
- Throughput: one beat per cycle within a column.
  - When the output is free, one bubble cycle follows each last beat, so C+1 cycles per column.
  - With `C==1`, one column every 2 cycles.
- Reset asserted mid-column: all state clears immediately and the in-flight LUT response is ignored. After release, the next beat must have `c_addr_i==0`, otherwise `seq_err_o` is set.
- Same-cycle pop and S1 write cannot occur, because the backpressure rule excludes it.

## Configuration
- `HALUT_DEC_SATURATE_EN` defined: each S1 addition saturates to [-2^(AccWidth-1), 2^(AccWidth-1)-1]. Later terms continue from the clamped value.
- `HALUT_DEC_SATURATE_EN` undefined: two's-complement wrap-around at `AccWidth`.

## Test plan
- C=4, `ready_i`=1, beats c=0..3 with m=5, LUT returns 10, -3, 7, 1 -> `valid_o` 2 cycles after the c=3 beat, `result_o`=15, `result_m_o`=5, `seq_err_o`=0.
- Two back-to-back columns, C=4, with `ready_i` held low 5 cycles after the first result -> first result held stable; `ready_o` low while output full and undrained; second sum correct; no LUT response lost.
- C=1, continuous `valid_i`, LUT returns -8 -> one result every 2 cycles, each `result_o`=-8 sign-extended.
- C=4, beats c=0,2,3 -> `seq_err_o` rises on the c=2 beat and stays high across following correct columns until `rst_ni` is pulsed.
- AccWidth=16, DataTypeWidth=16, C=4, all entries 0x7FFF -> with `HALUT_DEC_SATURATE_EN` `result_o`=0x7FFF; without it `result_o`=0xFFFC.
- Assert `rst_ni` after beat c=1 of a column -> all outputs 0 asynchronously; a fresh column c=0..3 of 1s yields `result_o`=4.
